// File: rtl/cordic_polar2rect.sv
// Iterative rotation-mode CORDIC: converts an unsigned magnitude and an integer
// angle in degrees into signed rectangular coordinates, one micro-rotation per clock.
module cordic_polar2rect #(
    parameter int DATA_WIDTH_IN = 11,
    parameter int ITER          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH_IN-1:0]      mag_in,
    input  logic [8:0]                    angle_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH_IN:0] x_out,
    output logic signed [DATA_WIDTH_IN:0] y_out,
    output logic [1:0]                    dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; in_ready and out_valid come straight from the state register.
    localparam int XW = DATA_WIDTH_IN + 6;
    localparam int PW = XW + 18;
    localparam logic [3:0]              LAST    = 4'(ITER - 1);
    localparam logic signed [17:0]      K_SCALE = 18'sh09B74;
    localparam logic signed [PW-1:0]    SAT     = PW'((1 << DATA_WIDTH_IN) - 1);
    localparam logic signed [PW-1:0]    HALF    = PW'(1 << 19);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROT   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [3:0]                   cnt_q;
    logic signed [XW-1:0]         x_q, y_q, x_d, y_d, x_sh, y_sh, x_init;
    logic signed [31:0]           z_q, z_d, z_init, rot;
    logic                         neg_q, neg_init;
    logic signed [DATA_WIDTH_IN:0] x_out_q, y_out_q;
    logic [8:0]                   ang_red;
    logic signed [9:0]            zdeg;

    function automatic logic signed [31:0] rot_angle(input logic [3:0] i);
        case (i)
            4'd0:    rot_angle = 32'sd2949120;
            4'd1:    rot_angle = 32'sd1740992;
            4'd2:    rot_angle = 32'sd919872;
            4'd3:    rot_angle = 32'sd466944;
            4'd4:    rot_angle = 32'sd234368;
            4'd5:    rot_angle = 32'sd117312;
            4'd6:    rot_angle = 32'sd58688;
            4'd7:    rot_angle = 32'sd29312;
            4'd8:    rot_angle = 32'sd14656;
            4'd9:    rot_angle = 32'sd7360;
            4'd10:   rot_angle = 32'sd3648;
            4'd11:   rot_angle = 32'sd1856;
            4'd12:   rot_angle = 32'sd896;
            4'd13:   rot_angle = 32'sd448;
            4'd14:   rot_angle = 32'sd256;
            default: rot_angle = 32'sd128;
        endcase
    endfunction

    // Removes the CORDIC gain and the 4 fractional bits in one multiply.
    function automatic logic signed [DATA_WIDTH_IN:0] scale(input logic signed [XW-1:0] v,
                                                            input logic neg);
        logic signed [PW-1:0] p;
        p = v * K_SCALE;
        p = (p + HALF) >>> 20;
        if (neg) p = -p;
        if (p > SAT) p = SAT;
        else if (p < -SAT) p = -SAT;
        scale = p[DATA_WIDTH_IN:0];
    endfunction

    // Fold the angle into [-90, 90] so the rotation stays inside CORDIC convergence.
    always_comb begin
        ang_red  = (angle_in >= 9'd360) ? angle_in - 9'd360 : angle_in;
        neg_init = 1'b0;
        if (ang_red <= 9'd90) begin
            zdeg = $signed({1'b0, ang_red});
        end else if (ang_red < 9'd270) begin
            zdeg     = $signed({1'b0, ang_red}) - 10'sd180;
            neg_init = 1'b1;
        end else begin
            zdeg = $signed({1'b0, ang_red}) - 10'sd360;
        end
        z_init = {{6{zdeg[9]}}, zdeg, 16'h0000};
        x_init = XW'({mag_in, 4'b0000});
    end

    always_comb begin
        x_sh = x_q >>> cnt_q;
        y_sh = y_q >>> cnt_q;
        rot  = rot_angle(cnt_q);
        if (!z_q[31]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - rot;
        end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + rot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ROT;
            ROT:     if (cnt_q == LAST) state_d = SCALE;
            SCALE:   state_d = DONE;
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        dbg_state_o = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            neg_q   <= 1'b0;
            x_out_q <= '0;
            y_out_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    x_q   <= x_init;
                    y_q   <= '0;
                    z_q   <= z_init;
                    neg_q <= neg_init;
                    cnt_q <= 4'd0;
                end
                ROT: begin
                    x_q   <= x_d;
                    y_q   <= y_d;
                    z_q   <= z_d;
                    cnt_q <= cnt_q + 4'd1;
                end
                SCALE: begin
                    x_out_q <= scale(x_q, neg_q);
                    y_out_q <= scale(y_q, neg_q);
                    cnt_q   <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign x_out = x_out_q;
    assign y_out = y_out_q;

endmodule

// File: tb/tb_cordic_polar2rect.sv
// Bench for cordic_polar2rect: vector table, backpressure, mid-rotation reset,
// random operands against a real-math model, and back-to-back throughput.
module tb_cordic_polar2rect;

    localparam int W      = 11;
    localparam int OW     = W + 1;
    localparam int EW     = 3 + 2 * OW;
    localparam int LAT    = 18;
    localparam int PERIOD = 19;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b1;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b1;
    logic [W-1:0]         mag_in    = '0;
    logic [8:0]           angle_in  = '0;
    logic                 in_ready, out_valid;
    logic signed [OW-1:0] x_out, y_out;
    logic [1:0]           dbg_state;

    int  checks     = 0;
    int  errors     = 0;
    int  cyc        = 0;
    int  accept_cyc = 0;
    int  unexpected = 0;
    bit  prev_valid = 1'b0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        int mag;
        int ang;
        int ex;
        int ey;
    } vec_t;
    vec_t tbl[16];

    cordic_polar2rect #(.DATA_WIDTH_IN(W), .ITER(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mag_in     (mag_in),
        .angle_in   (angle_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .x_out      (x_out),
        .y_out      (y_out),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    function automatic int ideal(input int mag, input int ang, input bit is_sin);
        real a, v;
        int r;
        a = ang * 3.14159265358979 / 180.0;
        v = mag * (is_sin ? $sin(a) : $cos(a));
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        if (r > 2047) r = 2047;
        if (r < -2047) r = -2047;
        return r;
    endfunction

    // The first edge that samples out_valid high is LAT edges after the accepting edge.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        #1;
        if (out_valid && !prev_valid) check("latency", cyc + 1 - accept_cyc, LAT, 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                unexpected++;
                checks++;
                errors++;
                $display("FAIL unexpected_result: got x=%0d y=%0d, want no result", x_out, y_out);
            end else begin
                e = exp_q.pop_front();
                check("x_out", int'(x_out), int'($signed(e[2*OW-1:OW])), int'(e[EW-1:2*OW]));
                check("y_out", int'(y_out), int'($signed(e[OW-1:0])), int'(e[EW-1:2*OW]));
            end
        end
        prev_valid = out_valid;
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input int mag, input int ang, input int ex, input int ey,
                        input int tol, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", int'(in_ready), 1, 0);
            return;
        end
        mag_in     = W'(mag);
        angle_in   = 9'(ang);
        in_valid   = 1'b1;
        accept_cyc = cyc + 1;
        if (push) exp_q.push_back({3'(tol), OW'(ex), OW'(ey)});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        out_ready = 1'b1;
        check("drain", exp_q.size(), 0, 0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    task automatic idle_quiet(input int n);
        repeat (n) @(negedge clk);
        check("no_spurious_result", unexpected, 0, 0);
    endtask

    initial begin
        int hx, hy, n, idx, mag, ang;
        int acc[3];
        int s_mag[3] = '{700, 1200, 300};
        int s_ang[3] = '{10, 100, 300};

        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int hx, hy, n, idx, mag, ang;
        int acc[3];
        int s_mag[3] = '{700, 1200, 300};
        int s_ang[3] = '{10, 100, 300};

        tbl[0]  = '{1000, 0,   1000,  0};
        tbl[1]  = '{1000, 90,  0,     1000};
        tbl[2]  = '{1000, 180, -1000, 0};
        tbl[3]  = '{1000, 270, 0,     -1000};
        tbl[4]  = '{2047, 225, -1447, -1447};
        tbl[5]  = '{1000, 400, 766,   643};
        tbl[6]  = '{500,  30,  433,   250};
        tbl[7]  = '{0,    123, 0,     0};
        tbl[8]  = '{2047, 45,  1447,  1447};
        tbl[9]  = '{1000, 360, 1000,  0};
        tbl[10] = '{1000, 511, -875,  485};
        tbl[11] = '{2047, 0,   2047,  0};
        tbl[12] = '{1,    90,  0,     1};
        tbl[13] = '{1000, 135, -707,  707};
        tbl[14] = '{1000, 300, 500,   -866};
        tbl[15] = '{2047, 180, -2047, 0};

        // Reset held with in_valid asserted: nothing may be accepted.
        rst      = 1'b1;
        in_valid = 1'b1;
        mag_in   = W'(1000);
        angle_in = 9'd0;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", int'(in_ready), 1, 0);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_x_out", int'(x_out), 0, 0);
        check("rst_y_out", int'(y_out), 0, 0);
        check("rst_state", int'(dbg_state), 0, 0);
        idle_quiet(25);
        check("rst_valid_not_taken", int'(in_ready), 1, 0);

        for (int i = 0; i < 16; i++) begin
            send(tbl[i].mag, tbl[i].ang, tbl[i].ex, tbl[i].ey, (tbl[i].mag == 0) ? 0 : 2, 1'b1);
            wait_drain(40, 1'b0);
        end

        // Backpressure in DONE with ignored in_valid.
        out_ready = 1'b0;
        send(1000, 180, -1000, 0, 2, 1'b1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", int'(out_valid), 1, 0);
        hx = int'(x_out);
        hy = int'(y_out);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = (k < 3);
            mag_in   = W'(2047);
            angle_in = 9'd90;
            check("bp_hold_x", int'(x_out), hx, 0);
            check("bp_hold_y", int'(y_out), hy, 0);
            check("bp_out_valid", int'(out_valid), 1, 0);
            check("bp_in_ready", int'(in_ready), 0, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_in_ready", int'(in_ready), 1, 0);
        check("bp_idle_out_valid", int'(out_valid), 0, 0);
        idle_quiet(25);

        // Reset in the 8th rotation cycle discards the operation.
        send(1000, 60, 0, 0, 0, 1'b0);
        while (cyc < accept_cyc + 7) @(negedge clk);
        check("mid_rot_state", int'(dbg_state), 1, 0);
        rst      = 1'b1;
        in_valid = 1'b1;
        mag_in   = W'(2047);
        angle_in = 9'd45;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrst_in_ready", int'(in_ready), 1, 0);
        check("midrst_out_valid", int'(out_valid), 0, 0);
        check("midrst_x_out", int'(x_out), 0, 0);
        check("midrst_y_out", int'(y_out), 0, 0);
        idle_quiet(25);
        send(500, 30, 433, 250, 2, 1'b1);
        wait_drain(40, 1'b0);

        // Random operands with random out_ready.
        repeat (8) begin
            mag = $urandom_range(0, 2047);
            ang = $urandom_range(0, 511);
            send(mag, ang, ideal(mag, ang, 1'b0), ideal(mag, ang, 1'b1), (mag == 0) ? 0 : 2, 1'b1);
            wait_drain(300, 1'b1);
        end

        // Back-to-back stream with in_valid held high.
        idx      = 0;
        n        = 0;
        mag_in   = W'(s_mag[0]);
        angle_in = 9'(s_ang[0]);
        in_valid = 1'b1;
        while (idx < 3 && n < 200) begin
            if (in_ready) begin
                acc[idx]   = cyc + 1;
                accept_cyc = cyc + 1;
                exp_q.push_back({3'(2), OW'(ideal(s_mag[idx], s_ang[idx], 1'b0)),
                                 OW'(ideal(s_mag[idx], s_ang[idx], 1'b1))});
                idx++;
                @(negedge clk);
                n++;
                if (idx < 3) begin
                    mag_in   = W'(s_mag[idx]);
                    angle_in = 9'(s_ang[idx]);
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                @(negedge clk);
                n++;
            end
        end
        in_valid = 1'b0;
        check("stream_accepts", idx, 3, 0);
        wait_drain(60, 1'b0);
        if (idx == 3) begin
            check("throughput_0_1", acc[1] - acc[0], PERIOD, 0);
            check("throughput_1_2", acc[2] - acc[1], PERIOD, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
